// File: rtl/uid_pkg.sv
// Shared UID geometry and helpers for the AR allocator and the R-channel ordering unit.
package uid_pkg;

   localparam int unsigned DEF_ID_WIDTH        = 4;
   localparam int unsigned DEF_MAX_OUTSTANDING = 16;
   localparam int unsigned DEF_PAYLOAD_W       = 64;

   localparam int unsigned ROW_W = $clog2(DEF_MAX_OUTSTANDING);
   localparam int unsigned COL_W = $clog2(DEF_MAX_OUTSTANDING);
   localparam int unsigned UID_W = ROW_W + COL_W;

   typedef logic [UID_W-1:0] uid_t;

   function automatic logic [ROW_W-1:0] uid_row(input uid_t uid);
      return uid[UID_W-1:COL_W];
   endfunction

   function automatic logic [COL_W-1:0] uid_col(input uid_t uid);
      return uid[COL_W-1:0];
   endfunction

   function automatic uid_t mk_uid(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/ar_uid_row_table.sv
// Per-row binding table: original ID, next allocation column and outstanding count per row.
module ar_uid_row_table #(
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned NUM_ROWS = 16,
   parameter int unsigned NUM_COLS = 16,
   parameter int unsigned ROW_W    = 4,
   parameter int unsigned COL_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_WIDTH-1:0] lookup_id,
   input  logic                budget_ok,
   output logic                hit,
   output logic [ROW_W-1:0]    hit_row,
   output logic [ROW_W-1:0]    free_row,
   output logic                can_alloc,
   input  logic                alloc_en,
   input  logic [ROW_W-1:0]    alloc_row,
   output logic [COL_W-1:0]    alloc_col,
   input  logic                rel_en,
   input  logic [ROW_W-1:0]    rel_row,
   output logic                rel_empty,
   input  logic [ROW_W-1:0]    rd_row,
   output logic [ID_WIDTH-1:0] rd_id
);
   import uid_pkg::*;

   localparam logic [COL_W:0]   CntMax  = (COL_W+1)'(NUM_COLS);
   localparam logic [COL_W-1:0] ColLast = COL_W'(NUM_COLS - 1);

   logic [NUM_ROWS-1:0] row_valid_q, row_valid_d;
   logic [ID_WIDTH-1:0] row_orig_id_q [NUM_ROWS];
   logic [ID_WIDTH-1:0] row_orig_id_d [NUM_ROWS];
   logic [COL_W-1:0]    alloc_idx_q   [NUM_ROWS];
   logic [COL_W-1:0]    alloc_idx_d   [NUM_ROWS];
   logic [COL_W:0]      row_cnt_q     [NUM_ROWS];
   logic [COL_W:0]      row_cnt_d     [NUM_ROWS];
   logic [NUM_ROWS-1:0] inc, dec;
   logic                free_avail;

   always_comb begin
      hit        = 1'b0;
      hit_row    = '0;
      free_avail = 1'b0;
      free_row   = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (row_valid_q[r] && row_orig_id_q[r] == lookup_id) begin
            hit     = 1'b1;
            hit_row = ROW_W'(r);
         end
      end
      // Descending scan leaves the lowest unbound row selected.
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!row_valid_q[r]) begin
            free_avail = 1'b1;
            free_row   = ROW_W'(r);
         end
      end
      can_alloc = budget_ok & (hit ? (row_cnt_q[hit_row] < CntMax) : free_avail);
   end

   assign alloc_col = alloc_idx_q[alloc_row];
   assign rel_empty = (row_cnt_q[rel_row] == '0);
   assign rd_id     = row_orig_id_q[rd_row];

   always_comb begin
      row_valid_d   = row_valid_q;
      row_orig_id_d = row_orig_id_q;
      alloc_idx_d   = alloc_idx_q;
      row_cnt_d     = row_cnt_q;
      inc           = '0;
      dec           = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         inc[r] = alloc_en && (alloc_row == ROW_W'(r));
         dec[r] = rel_en && (rel_row == ROW_W'(r)) && (row_cnt_q[r] != '0);
         if (inc[r]) begin
            row_valid_d[r]   = 1'b1;
            row_orig_id_d[r] = lookup_id;
            alloc_idx_d[r]   = (alloc_idx_q[r] == ColLast) ? '0 : alloc_idx_q[r] + 1'b1;
         end
         row_cnt_d[r] = row_cnt_q[r] + (COL_W+1)'(inc[r]) - (COL_W+1)'(dec[r]);
         // A same-edge accept keeps the row bound even when the last slot retires.
         if (dec[r] && !inc[r] && row_cnt_q[r] == (COL_W+1)'(1)) begin
            row_valid_d[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_valid_q <= '0;
         for (int r = 0; r < NUM_ROWS; r++) begin
            row_orig_id_q[r] <= '0;
            alloc_idx_q[r]   <= '0;
            row_cnt_q[r]     <= '0;
         end
      end else begin
         row_valid_q   <= row_valid_d;
         row_orig_id_q <= row_orig_id_d;
         alloc_idx_q   <= alloc_idx_d;
         row_cnt_q     <= row_cnt_d;
      end
   end

endmodule

// File: rtl/ar_uid_allocator.sv
// AR-side UID allocator: binds original IDs to rows, stamps {row,col} UIDs, restores IDs on free.
module ar_uid_allocator #(
   parameter int unsigned ID_WIDTH        = uid_pkg::DEF_ID_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = uid_pkg::DEF_MAX_OUTSTANDING,
   parameter int unsigned NUM_ROWS        = MAX_OUTSTANDING,
   parameter int unsigned NUM_COLS        = MAX_OUTSTANDING,
   parameter int unsigned PAYLOAD_W       = uid_pkg::DEF_PAYLOAD_W,
   localparam int unsigned ROW_W          = $clog2(NUM_ROWS),
   localparam int unsigned COL_W          = $clog2(NUM_COLS),
   localparam int unsigned UID_W          = ROW_W + COL_W,
   localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ar_in_valid,
   output logic                 ar_in_ready,
   input  logic [ID_WIDTH-1:0]  ar_in_id,
   input  logic [PAYLOAD_W-1:0] ar_in_payload,
   output logic                 ar_out_valid,
   input  logic                 ar_out_ready,
   output logic [UID_W-1:0]     ar_out_uid,
   output logic [PAYLOAD_W-1:0] ar_out_payload,
   input  logic                 free_req,
   input  logic [UID_W-1:0]     free_uid,
   output logic [ID_WIDTH-1:0]  restored_id,
   output logic [CNT_W-1:0]     outstanding_cnt,
   output logic                 free_err
);
   import uid_pkg::*;

   logic                 out_valid_q, out_valid_d;
   logic [UID_W-1:0]     out_uid_q, out_uid_d;
   logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 free_err_q;

   logic             hit, can_alloc, rel_empty;
   logic [ROW_W-1:0] hit_row, free_row, alloc_row, rel_row;
   logic [COL_W-1:0] alloc_col;
   logic             stage_ready, accept, free_ok, budget_ok;

   assign budget_ok   = (cnt_q < CNT_W'(MAX_OUTSTANDING));
   assign stage_ready = !out_valid_q | ar_out_ready;
   assign ar_in_ready = !rst & stage_ready & can_alloc;
   assign accept      = ar_in_valid & ar_in_ready;
   assign alloc_row   = hit ? hit_row : free_row;
   assign rel_row     = free_uid[UID_W-1:COL_W];
   assign free_ok     = free_req & !rel_empty;

   ar_uid_row_table #(
      .ID_WIDTH (ID_WIDTH),
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS),
      .ROW_W    (ROW_W),
      .COL_W    (COL_W)
   ) u_row_table (
      .clk       (clk),
      .rst       (rst),
      .lookup_id (ar_in_id),
      .budget_ok (budget_ok),
      .hit       (hit),
      .hit_row   (hit_row),
      .free_row  (free_row),
      .can_alloc (can_alloc),
      .alloc_en  (accept),
      .alloc_row (alloc_row),
      .alloc_col (alloc_col),
      .rel_en    (free_ok),
      .rel_row   (rel_row),
      .rel_empty (rel_empty),
      .rd_row    (rel_row),
      .rd_id     (restored_id)
   );

   always_comb begin
      out_valid_d   = out_valid_q;
      out_uid_d     = out_uid_q;
      out_payload_d = out_payload_q;
      cnt_d         = cnt_q;
      if (stage_ready) begin
         out_valid_d = accept;
         if (accept) begin
            out_uid_d     = {alloc_row, alloc_col};
            out_payload_d = ar_in_payload;
         end
      end
      unique case ({accept, free_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_uid_q     <= '0;
         out_payload_q <= '0;
         cnt_q         <= '0;
         free_err_q    <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_uid_q     <= out_uid_d;
         out_payload_q <= out_payload_d;
         cnt_q         <= cnt_d;
         free_err_q    <= free_req & rel_empty;
      end
   end

   assign ar_out_valid    = out_valid_q;
   assign ar_out_uid      = out_uid_q;
   assign ar_out_payload  = out_payload_q;
   assign outstanding_cnt = cnt_q;
   assign free_err        = free_err_q;

endmodule

// File: doc/ar_uid_allocator.md
Name: ar_uid_allocator

Overview:
Request-side counterpart of the R-channel ordering unit. It accepts AR requests carrying an original ID and assigns each one a unique ID {row,col}. The row is bound to that original ID while it has requests outstanding; the col is the row's next allocation slot. The remapped AR goes downstream through a registered output stage. On the response side, free requests from the ordering unit retire UIDs, and this block returns the restored original ID for each freed UID.

Parameters:
ID_WIDTH, 4, original AXI ID width
MAX_OUTSTANDING, 16, global cap on UIDs in flight
NUM_ROWS, MAX_OUTSTANDING, original IDs trackable concurrently
NUM_COLS, MAX_OUTSTANDING, outstanding slots per row
PAYLOAD_W, 64, packed AR payload (addr/len/size/burst), passed through untouched
ROW_W/COL_W/UID_W, derived: $clog2(NUM_ROWS), $clog2(NUM_COLS), ROW_W+COL_W

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
ar_in_valid  in  1  upstream request valid
ar_in_ready  out  1  upstream request accepted when valid&ready
ar_in_id  in  ID_WIDTH  original ID
ar_in_payload  in  PAYLOAD_W  AR payload
ar_out_valid  out  1  remapped request valid
ar_out_ready  in  1  downstream ready
ar_out_uid  out  UID_W  assigned {row,col}
ar_out_payload  out  PAYLOAD_W  registered payload
free_req  in  1  ordering unit retires a UID
free_uid  in  UID_W  UID being retired
restored_id  out  ID_WIDTH  orig ID of free_uid row; combinational
outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  UIDs in flight
free_err  out  1  one-cycle pulse: free_req hit a row with count 0

Behaviour:
- Row table, per row: row_valid, row_orig_id, alloc_idx[COL_W], row_cnt[COL_W+1].
- Lookup (comb): hit_row = the row with row_valid & row_orig_id==ar_in_id; at most one can match.
- On a miss, the candidate is the lowest-index row with !row_valid.
- can_alloc is set when all of the following hold:
  - hit: row_cnt[hit_row] < NUM_COLS;
  - miss: a free row exists;
  - in both cases, outstanding_cnt < MAX_OUTSTANDING.
- Output stage is one register. stage_ready = !ar_out_valid | ar_out_ready.
- ar_in_ready = stage_ready & can_alloc. It is a function of ar_in_id, which is legal because valid never depends on ready.
- Accept: the stage loads uid={row, alloc_idx[row]} and the payload. alloc_idx[row] increments, wrapping NUM_COLS-1→0. row_cnt[row] increments.
  - On a miss, row_valid←1 and row_orig_id←ar_in_id in the same edge.
- Latency: accept at edge N → ar_out_valid high after N. The output holds stable while ar_out_valid & !ar_out_ready. Full throughput of 1/cycle when ar_out_ready=1.
- Free: row=free_uid[UID_W-1:COL_W]. row_cnt[row] decrements. If the count reaches 0 and there is no same-edge accept to that row, row_valid←0.
  - free_uid col is not checked. Per-row in-order release guarantees it equals the oldest slot.
- alloc_idx is NEVER reset on row unbind. It must stay in lockstep with the ordering unit's per-row release_idx across rebinding.
- Same-edge accept+free, same row: row_cnt unchanged, row stays bound. Different rows: both updates apply.
- outstanding_cnt changes by +accept −free: +1, −1 or 0.
- Free with row_cnt==0: no state change, free_err pulses.
- Reset (sync, rst high at an edge):
  - ar_out_valid=0, ar_out_uid=0, ar_out_payload=0.
  - Every row: row_valid=0, alloc_idx=0, row_cnt=0.
  - outstanding_cnt=0, free_err=0.
  - ar_in_ready=0 while rst is high. Reset mid-transfer drops the staged request.

Decomposition:
- Package uid_pkg: ROW_W, COL_W, UID_W localparams; typedef uid_t; functions uid_row(), uid_col(), mk_uid(). The ordering unit shares this package.
- One sub-module, ar_uid_row_table, holding the row state. It exposes:
  - lookup (hit, hit_row, free_row, can_alloc);
  - alloc/free update ports;
  - restored_id read.
- Top level keeps the output register, handshakes and outstanding_cnt.

Test Plan:
- Reset, then AR id=3 ×3 with ar_out_ready=1 → uids 0x00, 0x01, 0x02 on consecutive cycles; outstanding_cnt=3.
- id=3 then id=5 → 0x00, 0x10. free_uid=0x10 → restored_id=5, row 1 unbound. Then id=7 → uid 0x11 (row 1 reused, alloc_idx persists).
- 16 AR with id=2 and no frees → 17th sees ar_in_ready=0. Free 0x00 → 17th accepted as uid 0x00 (col wrap).
- ar_out_ready=0 for 4 cycles with a request staged → ar_out_uid/payload stable, ar_in_ready=0. Release → throughput resumes.
- Same cycle: accept id=4 (row 0, cnt 1→2) and free 0x00 → row_cnt stays 1, row_valid=1, outstanding_cnt unchanged.
- free_req on an unbound row → free_err pulse, counts unchanged. rst asserted with ar_out_valid=1 → ar_out_valid=0 next cycle, all rows cleared.
